// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: start/stop sequencing for a 0..DIGIT_MAX up/down digit counter,
// with wrap, ping-pong (endpoint dwell) and one-shot run modes.
module updown_count_ctrl_btn #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);
    localparam int unsigned CW = $clog2(CYCLES + 1);
    logic [1:0]    sync_q;
    logic          level_q, level_d, prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    // Any sample that agrees with the accepted level restarts the stability count.
    always_comb begin
        cnt_d   = (sync_q[1] != level_q) ? cnt_q + CW'(1) : '0;
        level_d = (cnt_d == CW'(CYCLES)) ? ~level_q : level_q;
        cnt_d   = (cnt_d == CW'(CYCLES)) ? '0 : cnt_d;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end
    assign press_o = level_q & ~prev_q;
endmodule

module updown_count_ctrl #(
    parameter logic [3:0]  DIGIT_MAX       = 4'd9,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [3:0]  PAUSE_TICKS     = 4'd2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       btn_start_i,
    input  logic       btn_stop_i,
    input  logic [1:0] mode_i,
    input  logic [3:0] q_i,
    output logic       cnt_en_o,
    output logic       cnt_dir_o,
    output logic       cnt_clr_o,
    output logic       running_o,
    output logic       done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DWELL, DONE} state_e;
    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] dwell_q, dwell_d;
    logic       dir_q, dir_d, clr_q, clr_d, run_q, done_q;
    logic       start, stop, term, live;

    updown_count_ctrl_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_start_i), .press_o(start)
    );
    updown_count_ctrl_btn #(.CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_stop_i), .press_o(stop)
    );

    // The clear cycle still sees the stale q, so counting and endpoint checks wait it out.
    assign term = (mode_q == 2'b10) ? (dir_q ? q_i == 4'd0 : q_i >= DIGIT_MAX)
                                    : (mode_q == 2'b11) & (q_i >= DIGIT_MAX);
    assign live     = tick_i & (state_q == RUN) & ~clr_q;
    assign cnt_en_o = live & ~term;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        clr_d   = 1'b0;
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
        end else if (start && !stop && (state_q == IDLE || state_q == DONE)) begin
            state_d = RUN;
            mode_d  = mode_i;
            dir_d   = (mode_i == 2'b01);
            clr_d   = 1'b1;
        end else if (live && term) begin
            state_d = (mode_q == 2'b11) ? DONE : DWELL;
            dir_d   = (mode_q == 2'b11) ? dir_q : ~dir_q;
            dwell_d = (mode_q == 2'b11) ? dwell_q : PAUSE_TICKS;
        end else if (state_q == DWELL) begin
            state_d = (dwell_q == 4'd0 || (tick_i && dwell_q == 4'd1)) ? RUN : DWELL;
            dwell_d = (tick_i && dwell_q != 4'd0) ? dwell_q - 4'd1 : dwell_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            dir_q   <= 1'b0;
            dwell_q <= 4'd0;
            clr_q   <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            clr_q   <= clr_d;
            run_q   <= (state_d == RUN) || (state_d == DWELL);
            done_q  <= (state_d == DONE);
        end
    end

    assign cnt_dir_o = dir_q;
    assign cnt_clr_o = clr_q;
    assign running_o = run_q;
    assign done_o    = done_q;
endmodule
